fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Shares one multi-cycle `fpu` adder between two requesters. Round-robin arbitration over a valid/ready request handshake. For each transaction the block latches both operands, restarts the FPU through its active-low reset, and waits for the FPU to publish a result. It then returns `data_out`/`status_out` to the granted requester as a one-cycle response pulse. Sits directly between the `fpu` instance and the operand sources in the FPU top level.

## Interface
- `RST_HOLD`, 2 — cycles `fpu_rst_n` is held low per transaction (≥1).
- `TIMEOUT_CYCLES`, 64 — RUN-state watchdog limit; used only with `FPU_ARB_TIMEOUT_EN`.
- `clock100KHz` in 1 — single clock, all logic on rising edge.
- `reset` in 1 — synchronous, active-high.
- `req0_valid` in 1 / `req0_ready` out 1 — requester 0 handshake.
- `req0_op_a`, `req0_op_b` in 32 — requester 0 operands.
- `req1_valid` in 1 / `req1_ready` out 1 — requester 1 handshake.
- `req1_op_a`, `req1_op_b` in 32 — requester 1 operands.
- `rsp0_valid`, `rsp1_valid` out 1 — one-cycle response pulse per requester.
- `rsp_data` out 32 / `rsp_status` out 4 — shared response bus, qualified by `rspN_valid`.
- `busy` out 1 — high in every state except IDLE.
- `fpu_op_a`, `fpu_op_b` out 32 — driven to the FPU operand inputs.
- `fpu_rst_n` out 1 — drives the FPU `reset` (active-low).
- `fpu_data_in` in 32 / `fpu_status_in` in 4 — FPU `data_out` / `status_out`.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - `reqN_ready` is combinational: high only for the granted requester, and only when its `reqN_valid` is high.
  - Accept on `valid && ready`. On accept, capture operands into `op_a_q`/`op_b_q`, record `grant_q`, update `last_grant`, then go to LOAD.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester ≠ `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- LOAD: `fpu_rst_n=0` for exactly `RST_HOLD` cycles (down-counter), then go to RUN.
- RUN:
  - `fpu_rst_n=1`.
  - On the first cycle with `fpu_status_in != 4'b0000`, capture `fpu_data_in` into `rsp_data` and `fpu_status_in` into `rsp_status`, then go to RESP.
- RESP: `rsp<grant_q>_valid=1` for exactly one cycle, then go to IDLE. `rsp_data`/`rsp_status` hold until the next capture.
- `fpu_op_a`/`fpu_op_b` always drive `op_a_q`/`op_b_q`; they are stable from LOAD through RESP.
- `fpu_rst_n` stays 0 in IDLE, which parks the FPU in reset between transactions.
- Status is forwarded exactly as the FPU reports it; no re-encoding.
- `reqN_valid` deasserting before acceptance: nothing is captured and no response is issued.
- New requests during LOAD/RUN/RESP are not accepted (both readies low); they remain pending.
- `reset` asserted mid-transaction: all state returns to reset values next edge, the in-flight transaction is dropped, and no response is issued.

## Timing
- Reset values:
  - `req0_ready=req1_ready=0`, `rsp0_valid=rsp1_valid=0`.
  - `rsp_data=0`, `rsp_status=0`, `busy=0`.
  - `fpu_op_a=fpu_op_b=0`, `fpu_rst_n=0`.
  - State IDLE, `last_grant=1`.
- Accept at edge T, giving:
  - LOAD during cycles T+1 … T+RST_HOLD.
  - RUN from T+RST_HOLD+1.
- If `fpu_status_in` is first nonzero in cycle R, `rspN_valid` is high in cycle R+1.
- Latency accept→response = `RST_HOLD` + FPU latency + 2 cycles. Back-to-back throughput: one transaction per latency + 1 cycle (IDLE cycle for arbitration).
- `busy` rises the cycle after accept and falls the cycle after RESP.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - RUN carries a cycle counter cleared on entry.
  - If it reaches `TIMEOUT_CYCLES` with `fpu_status_in` still 0, go to RESP with `rsp_data=32'h0` and `rsp_status=4'b0000`. All-zero status is the timeout indication.
- Undefined: no counter; RUN waits indefinitely for nonzero status.

## Test plan
(Bench uses a behavioural FPU stub: after `fpu_rst_n` rises, it drives `fpu_status_in=4'b0001` and `fpu_data_in=op_a^op_b` after D cycles.)
- Single request: req0 with A=32'h4080_0000, B=32'h0000_0001, D=6, `RST_HOLD`=2 → `req0_ready` high in the accept cycle; `fpu_rst_n` low for 2 cycles; `rsp0_valid` pulses once 10 cycles after accept with `rsp_data`=32'h4080_0001, `rsp_status`=4'b0001; `rsp1_valid` never high.
- Simultaneous requests from both ports, held → order is req0, req1, req0, req1; each `rspN_valid` matches its own operands.
- Request during busy: req1 asserts while req0 is in RUN → `req1_ready` stays 0 until IDLE; then req1 is granted and its result returns.
- Reset mid-RUN: assert `reset` for 1 cycle → next cycle all outputs are at reset values; no `rsp*_valid` for the dropped transaction; a fresh req0 completes normally.
- Timeout (macro on, `TIMEOUT_CYCLES`=64, stub never responds) → `rsp0_valid` after 64 RUN cycles with `rsp_data`=0, `rsp_status`=4'b0000. With the macro off, `busy` stays high for 200 cycles and no response is issued.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: bundle of requester handshakes, response bus and
// FPU-facing signals for fpu_arbiter.
//   slave  : arbiter side (drives readies, responses, busy, FPU operands/reset)
//   master : environment side (requesters plus the FPU result/status)
interface fpu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_op_a;
   logic [31:0] req0_op_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_op_a;
   logic [31:0] req1_op_b;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_status;
   logic        busy;
   logic [31:0] fpu_op_a;
   logic [31:0] fpu_op_b;
   logic        fpu_rst_n;
   logic [31:0] fpu_data_in;
   logic [3:0]  fpu_status_in;

   modport slave (
      input  req0_valid, req0_op_a, req0_op_b,
      input  req1_valid, req1_op_a, req1_op_b,
      input  fpu_data_in, fpu_status_in,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_data, rsp_status,
      output busy, fpu_op_a, fpu_op_b, fpu_rst_n
   );

   modport master (
      output req0_valid, req0_op_a, req0_op_b,
      output req1_valid, req1_op_a, req1_op_b,
      output fpu_data_in, fpu_status_in,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data, rsp_status,
      input  busy, fpu_op_a, fpu_op_b, fpu_rst_n
   );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one multi-cycle FPU adder between two
// requesters. Per transaction: latch operands, hold the FPU in reset for
// RST_HOLD cycles, wait for nonzero status, return a one-cycle response.
// Ports: clock100KHz, reset (sync, active-high), bus (fpu_arbiter_if.slave).
// Optional macro FPU_ARB_TIMEOUT_EN: RUN watchdog of TIMEOUT_CYCLES cycles,
// reported as an all-zero response.
module fpu_arbiter #(
   parameter int unsigned RST_HOLD       = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic           clock100KHz,
   input logic           reset,
   fpu_arbiter_if.slave  bus
);

   localparam int CW = $clog2(RST_HOLD + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   generate
      if (RST_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
         $error("fpu_arbiter: RST_HOLD and TIMEOUT_CYCLES must be >= 1");
      end
   endgenerate

   state_t          state_q;
   logic [31:0]     op_a_q;
   logic [31:0]     op_b_q;
   logic            grant_q;
   logic            last_grant_q;
   logic [CW-1:0]   hold_q;
   logic            fpu_rst_n_q;
   logic            rsp0_valid_q;
   logic            rsp1_valid_q;
   logic [31:0]     rsp_data_q;
   logic [3:0]      rsp_status_q;
   logic            busy_q;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]   tmo_q;
`endif

   // Requester 1 wins when it is the only one asking, or on a tie when
   // requester 0 was served last.
   logic idle;
   logic grant_d;
   logic accept;

   assign idle    = (state_q == IDLE);
   assign grant_d = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
   assign accept  = idle & (bus.req0_valid | bus.req1_valid);

   assign bus.req0_ready = idle & bus.req0_valid & ~grant_d;
   assign bus.req1_ready = idle & grant_d;

   assign bus.fpu_op_a   = op_a_q;
   assign bus.fpu_op_b   = op_b_q;
   assign bus.fpu_rst_n  = fpu_rst_n_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.busy       = busy_q;

   always_ff @(posedge clock100KHz) begin
      if (reset) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         hold_q       <= '0;
         fpu_rst_n_q  <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
         busy_q       <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  op_a_q       <= grant_d ? bus.req1_op_a : bus.req0_op_a;
                  op_b_q       <= grant_d ? bus.req1_op_b : bus.req0_op_b;
                  grant_q      <= grant_d;
                  last_grant_q <= grant_d;
                  hold_q       <= CW'(RST_HOLD - 1);
                  busy_q       <= 1'b1;
                  state_q      <= LOAD;
               end
            end
            LOAD: begin
               if (hold_q == '0) begin
                  fpu_rst_n_q <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
                  tmo_q       <= '0;
`endif
                  state_q     <= RUN;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            RUN: begin
               if (bus.fpu_status_in != 4'b0000) begin
                  rsp_data_q   <= bus.fpu_data_in;
                  rsp_status_q <= bus.fpu_status_in;
                  rsp0_valid_q <= ~grant_q;
                  rsp1_valid_q <= grant_q;
                  fpu_rst_n_q  <= 1'b0;
                  state_q      <= RESP;
               end
`ifdef FPU_ARB_TIMEOUT_EN
               else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data_q   <= '0;
                  rsp_status_q <= '0;
                  rsp0_valid_q <= ~grant_q;
                  rsp1_valid_q <= grant_q;
                  fpu_rst_n_q  <= 1'b0;
                  state_q      <= RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            RESP: begin
               rsp0_valid_q <= 1'b0;
               rsp1_valid_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed stimulus with a behavioural FPU stub; responses
// are checked against a scoreboard queue filled when requests are accepted.
module tb_fpu_arbiter;

   localparam int unsigned RH  = 2;
   localparam int unsigned TMO = 64;
   localparam int          D   = 6;
`ifdef FPU_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct {
      int          port;
      logic [31:0] data;
      logic [3:0]  st;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic stub_en;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   int   rsp_cnt = 0;
   bit   rsp1_seen;
   int   scnt;

   exp_t sb[$];
   int   acc_log[$];
   int   acc_cyc[$];

   fpu_arbiter_if bus ();

   fpu_arbiter #(.RST_HOLD(RH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock100KHz (clk),
      .reset       (reset),
      .bus         (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // FPU stub: D cycles after fpu_rst_n rises, publish op_a^op_b, status 1.
   always @(posedge clk) begin
      if (!bus.fpu_rst_n || !stub_en) begin
         scnt              <= 0;
         bus.fpu_status_in <= 4'b0000;
         bus.fpu_data_in   <= 32'h0;
      end else if (bus.fpu_status_in == 4'b0000) begin
         if (scnt == D - 1) begin
            bus.fpu_status_in <= 4'b0001;
            bus.fpu_data_in   <= bus.fpu_op_a ^ bus.fpu_op_b;
         end else begin
            scnt <= scnt + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input int p, input logic [31:0] a,
                       input logic [31:0] b);
      exp_t e;
      e.port = p;
      if (stub_en) begin
         e.data = a ^ b;
         e.st   = 4'b0001;
         e.cyc  = cyc + RH + D + 2;
      end else begin
         e.data = 32'h0;
         e.st   = 4'b0000;
         e.cyc  = cyc + RH + TMO + 1;
      end
      if (stub_en || TMO_EN) sb.push_back(e);
      acc_log.push_back(p);
      acc_cyc.push_back(cyc);
   endtask

   // Stimulus-side capture of accepted requests.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.req0_valid && bus.req0_ready)
            push(0, bus.req0_op_a, bus.req0_op_b);
         if (bus.req1_valid && bus.req1_ready)
            push(1, bus.req1_op_a, bus.req1_op_b);
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (bus.rsp0_valid || bus.rsp1_valid) begin
         exp_t e;
         int   p;
         rsp_cnt++;
         if (bus.rsp1_valid) rsp1_seen = 1'b1;
         p = (bus.rsp0_valid && bus.rsp1_valid) ? 2 :
             (bus.rsp1_valid ? 1 : 0);
         if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_rsp: got port %0d data %h expected none",
                     p, bus.rsp_data);
         end else begin
            e = sb.pop_front();
            chk("rsp_port", p, e.port);
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_status", {28'h0, bus.rsp_status}, {28'h0, e.st});
            chk("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_acc(input int target, input int budget);
      int n = 0;
      while (acc_log.size() < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (acc_log.size() < target) begin
         n_run++;
         n_fail++;
         $display("FAIL accept_timeout: got %0d expected %0d",
                  acc_log.size(), target);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb.size() != 0 || bus.busy) && n < budget);
      if (sb.size() != 0 || bus.busy) begin
         n_run++;
         n_fail++;
         $display("FAIL idle_timeout: got pending %0d expected 0", sb.size());
      end
   endtask

   task automatic wait_run(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.fpu_rst_n && n < budget);
      chk("reach_run", bus.fpu_rst_n, 1'b1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int exp_ord[4];
      bit bad;
      int r0;

      reset = 1'b1;
      stub_en = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_op_a = 32'h0;
      bus.req0_op_b = 32'h0;
      bus.req1_op_a = 32'h0;
      bus.req1_op_b = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", bus.req0_ready, 1'b0);
      chk("rst_ready1", bus.req1_ready, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_fpu_rst_n", bus.fpu_rst_n, 1'b0);
      chk("rst_data", bus.rsp_data, 32'h0);
      chk("rst_fpu_op_a", bus.fpu_op_a, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single request on port 0.
      rsp1_seen = 1'b0;
      @(posedge clk);
      #1;
      bus.req0_op_a = 32'h4080_0000;
      bus.req0_op_b = 32'h0000_0001;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      chk("t1_ready0", bus.req0_ready, 1'b1);
      chk("t1_ready1", bus.req1_ready, 1'b0);
      @(posedge clk);
      #1 bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("t1_load1_rst_n", bus.fpu_rst_n, 1'b0);
      chk("t1_busy", bus.busy, 1'b1);
      @(negedge clk);
      chk("t1_load2_rst_n", bus.fpu_rst_n, 1'b0);
      @(negedge clk);
      chk("t1_run_rst_n", bus.fpu_rst_n, 1'b1);
      wait_idle(100);
      chk("t1_rsp1_never", rsp1_seen, 1'b0);
      chk("t1_rsp_data_hold", bus.rsp_data, 32'h4080_0001);

      // Both requesters held: strict alternation starting with port 0.
      pulse_reset();
      base = acc_log.size();
      bus.req0_op_a = 32'h1111_0000;
      bus.req0_op_b = 32'h0000_2222;
      bus.req1_op_a = 32'hA5A5_A5A5;
      bus.req1_op_b = 32'h0F0F_0F0F;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      wait_acc(base + 4, 200);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_idle(100);
      exp_ord = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         if (acc_log.size() > base + i)
            chk("t2_order", acc_log[base + i], exp_ord[i]);
         else
            chk("t2_order_missing", acc_log.size(), base + i + 1);
      end
      if (acc_cyc.size() > base + 1)
         chk("t2_throughput", acc_cyc[base + 1] - acc_cyc[base],
             RH + D + 3);

      // Request arriving while busy is held off until IDLE.
      base = acc_log.size();
      bus.req0_op_a = 32'h3F80_0000;
      bus.req0_op_b = 32'h4000_0000;
      bus.req1_op_a = 32'h1234_5678;
      bus.req1_op_b = 32'h8765_4321;
      @(posedge clk);
      #1 bus.req0_valid = 1'b1;
      wait_acc(base + 1, 20);
      bus.req0_valid = 1'b0;
      wait_run(10);
      bus.req1_valid = 1'b1;
      bad = 1'b0;
      for (int n = 0; n < 50 && bus.busy; n++) begin
         if (bus.req1_ready) bad = 1'b1;
         @(negedge clk);
      end
      chk("t3_ready1_held_low", bad, 1'b0);
      chk("t3_ready1_in_idle", bus.req1_ready, 1'b1);
      wait_acc(base + 2, 10);
      bus.req1_valid = 1'b0;
      wait_idle(100);
      if (acc_log.size() > base + 1)
         chk("t3_second_port", acc_log[base + 1], 1);

      // Reset mid-RUN drops the transaction.
      base = acc_log.size();
      bus.req0_op_a = 32'hDEAD_0000;
      bus.req0_op_b = 32'h0000_BEEF;
      @(posedge clk);
      #1 bus.req0_valid = 1'b1;
      wait_acc(base + 1, 20);
      bus.req0_valid = 1'b0;
      wait_run(10);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      r0 = rsp_cnt;
      chk("t4_busy", bus.busy, 1'b0);
      chk("t4_fpu_rst_n", bus.fpu_rst_n, 1'b0);
      chk("t4_rsp0", bus.rsp0_valid, 1'b0);
      chk("t4_rsp1", bus.rsp1_valid, 1'b0);
      chk("t4_rsp_data", bus.rsp_data, 32'h0);
      chk("t4_rsp_status", {28'h0, bus.rsp_status}, 32'h0);
      chk("t4_fpu_op_a", bus.fpu_op_a, 32'h0);
      chk("t4_fpu_op_b", bus.fpu_op_b, 32'h0);
      repeat (20) @(negedge clk);
      chk("t4_no_dropped_rsp", rsp_cnt, r0);
      @(posedge clk);
      #1;
      bus.req0_op_a = 32'h0000_00FF;
      bus.req0_op_b = 32'h0000_0F0F;
      bus.req0_valid = 1'b1;
      wait_acc(base + 2, 20);
      bus.req0_valid = 1'b0;
      wait_idle(100);
      chk("t4_fresh_rsp", rsp_cnt, r0 + 1);

      // FPU never answers.
      stub_en = 1'b0;
      base = acc_log.size();
      r0 = rsp_cnt;
      @(posedge clk);
      #1 bus.req0_valid = 1'b1;
      wait_acc(base + 1, 20);
      bus.req0_valid = 1'b0;
      if (TMO_EN) begin
         wait_idle(150);
         chk("t5_timeout_rsp", rsp_cnt, r0 + 1);
         chk("t5_timeout_status", {28'h0, bus.rsp_status}, 32'h0);
      end else begin
         bad = 1'b0;
         for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.busy) bad = 1'b1;
         end
         chk("t5_busy_held", bad, 1'b0);
         chk("t5_no_rsp", rsp_cnt, r0);
         pulse_reset();
      end
      stub_en = 1'b1;

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
